wb_arb2_pipelined: RTL and testbench

Two-master to one-slave arbiter for the Wishbone B4 pipelined bus. It shares a single slave port (memory/IPL target) between two bus masters, for example the IPL read master and a write/DMA master. Grant is round-robin and is held for a master's entire CYC envelope. An outstanding-transfer counter tracks strobes accepted but not yet acknowledged.

---
 rtl/wb_arb2_pipelined_pkg.sv | 18 +
 rtl/wb_arb2_pipelined_if.sv | 26 ++
 rtl/wb_arb2_pipelined_rr2.sv | 45 ++++
 rtl/wb_arb2_pipelined.sv | 144 ++++++++++++++
 tb/tb_wb_arb2_pipelined.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb2_pipelined_pkg.sv
// Shared grant encodings and default widths for the two-master Wishbone arbiter.
// WB_ARB2_TIMEOUT_EN adds the default watchdog limit.
package wb_arb2_pipelined_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 4;
`ifdef WB_ARB2_TIMEOUT_EN
    localparam int DEF_TIMEOUT    = 255;
`endif

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_M0   = 2'b01,
        GNT_M1   = 2'b10
    } gnt_e;

endpackage

// File: rtl/wb_arb2_pipelined_if.sv
// Wishbone B4 pipelined bus bundle.
// The master modport drives the request side, and the slave modport drives the response side.
interface wb_arb2_pipelined_if
    import wb_arb2_pipelined_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat_w;
    logic [DATA_WIDTH-1:0] dat_r;
    logic                  ack;
    logic                  err;
    logic                  stall;

    modport master (output cyc, stb, we, adr, dat_w,
                    input  dat_r, ack, err, stall);

    modport slave  (input  cyc, stb, we, adr, dat_w,
                    output dat_r, ack, err, stall);

endinterface

// File: rtl/wb_arb2_pipelined_rr2.sv
// Round-robin grant register for two requesters.
// A grant is held until its owner drops cyc, and it is re-chosen only when idle or released.
module wb_arb2_pipelined_rr2
    import wb_arb2_pipelined_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [1:0] req_i,
    input  logic       release_i,
    output gnt_e       gnt_o,
    output logic       gnt_chg_o
);

    gnt_e gnt_q, gnt_d;
    logic last_q, last_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            gnt_q  <= GNT_NONE;
            last_q <= 1'b1;
        end else begin
            gnt_q  <= gnt_d;
            last_q <= last_d;
        end
    end

    // last_q = 1 means m1 was granted last, so m0 wins a tie.
    always_comb begin
        gnt_d  = gnt_q;
        last_d = last_q;
        if (gnt_q == GNT_NONE || release_i) begin
            case (req_i)
                2'b01:   gnt_d = GNT_M0;
                2'b10:   gnt_d = GNT_M1;
                2'b11:   gnt_d = last_q ? GNT_M0 : GNT_M1;
                default: gnt_d = GNT_NONE;
            endcase
            if (gnt_d != GNT_NONE) last_d = (gnt_d == GNT_M1);
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_chg_o = (gnt_d != gnt_q);

endmodule

// File: rtl/wb_arb2_pipelined.sv
// Two-master to one-slave Wishbone B4 pipelined arbiter with an outstanding-transfer counter.
// Define WB_ARB2_TIMEOUT_EN to add a no-ack watchdog that forces an error to the granted master.
module wb_arb2_pipelined
    import wb_arb2_pipelined_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
`ifdef WB_ARB2_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = DEF_TIMEOUT
`endif
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    wb_arb2_pipelined_if.slave   m0,
    wb_arb2_pipelined_if.slave   m1,
    wb_arb2_pipelined_if.master  s,
    output logic [1:0]           gnt_o,
    output logic [CNT_WIDTH-1:0] outstanding_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    gnt_e                  gnt;
    logic                  gnt_chg;
    logic                  rel;
    logic                  to_hit;
    logic                  inc, dec;
    logic [ADDR_WIDTH-1:0] adr_mux;
    logic [DATA_WIDTH-1:0] dat_mux;
    logic [CNT_WIDTH-1:0]  out_q, out_d;

    assign rel = (gnt == GNT_M0 && !m0.cyc) || (gnt == GNT_M1 && !m1.cyc);

    wb_arb2_pipelined_rr2 u_rr2 (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .req_i     ({m1.cyc, m0.cyc}),
        .release_i (rel),
        .gnt_o     (gnt),
        .gnt_chg_o (gnt_chg)
    );

    always_comb begin
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        s.we    = 1'b0;
        adr_mux = '0;
        dat_mux = '0;
        case (gnt)
            GNT_M0: begin
                s.cyc   = m0.cyc;
                s.stb   = m0.stb & m0.cyc;
                s.we    = m0.we;
                adr_mux = m0.adr;
                dat_mux = m0.dat_w;
            end
            GNT_M1: begin
                s.cyc   = m1.cyc;
                s.stb   = m1.stb & m1.cyc;
                s.we    = m1.we;
                adr_mux = m1.adr;
                dat_mux = m1.dat_w;
            end
            default: ;
        endcase
    end

    assign s.adr   = adr_mux;
    assign s.dat_w = dat_mux;

    // Responses reach only the granted master, so stray acks after a release are dropped.
    always_comb begin
        m0.stall = 1'b1;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m1.stall = 1'b1;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        case (gnt)
            GNT_M0: begin
                m0.stall = s.stall;
                m0.ack   = s.ack;
                m0.err   = s.err | to_hit;
            end
            GNT_M1: begin
                m1.stall = s.stall;
                m1.ack   = s.ack;
                m1.err   = s.err | to_hit;
            end
            default: ;
        endcase
    end

    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;

    assign inc = s.stb & ~s.stall;
    assign dec = (s.ack | s.err) & s.cyc;

    always_comb begin
        out_d = out_q;
        if (gnt_chg || to_hit) begin
            out_d = '0;
        end else if (inc && !dec && out_q != CNT_MAX) begin
            out_d = out_q + 1'b1;
        end else if (dec && !inc && out_q != '0) begin
            out_d = out_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) out_q <= '0;
        else           out_q <= out_d;
    end

    assign outstanding_o = out_q;
    assign gnt_o         = gnt;

`ifdef WB_ARB2_TIMEOUT_EN
    localparam int             WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic            wd_run;
    logic [WD_W-1:0] wd_q, wd_d;

    // Counts cycles spent waiting on a response; the TIMEOUT-th such cycle raises the error.
    always_comb begin
        wd_run = s.cyc && (out_q != '0) && !(s.ack || s.err);
        to_hit = wd_run && (wd_q == WD_LAST);
        wd_d   = '0;
        if (wd_run && !to_hit && !gnt_chg) wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) wd_q <= '0;
        else           wd_q <= wd_d;
    end
`else
    assign to_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arb2_pipelined.sv
// Directed table-driven bench for wb_arb2_pipelined, plus hand sequences for the multi-cycle corner cases.
// Under WB_ARB2_TIMEOUT_EN, the bench builds the DUT with TIMEOUT=8 and expects the watchdog error.
module tb_wb_arb2_pipelined;

    logic       clk_i    = 1'b0;
    logic       reset_ni = 1'b0;
    logic [1:0] gnt_o;
    logic [3:0] outstanding_o;
    int         n_cmp    = 0;
    int         n_fail   = 0;

    wb_arb2_pipelined_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) m0_bus ();
    wb_arb2_pipelined_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) m1_bus ();
    wb_arb2_pipelined_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) s_bus ();

    wb_arb2_pipelined #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .CNT_WIDTH  (4)
`ifdef WB_ARB2_TIMEOUT_EN
        ,
        .TIMEOUT    (8)
`endif
    ) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .m0            (m0_bus.slave),
        .m1            (m1_bus.slave),
        .s             (s_bus.master),
        .gnt_o         (gnt_o),
        .outstanding_o (outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        m0_cyc, m0_stb;
        logic [15:0] m0_adr;
        logic        m1_cyc, m1_stb;
        logic [15:0] m1_adr;
        logic        ack, stall;
        logic [1:0]  e_gnt;
        logic        e_cyc, e_stb;
        logic [15:0] e_adr;
        logic        e_m0_ack, e_m1_ack, e_m0_stall, e_m1_stall;
        logic [3:0]  e_out;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic m0c, m0s, input logic [15:0] m0a,
                                input logic m1c, m1s, input logic [15:0] m1a,
                                input logic ack, stall,
                                input logic [1:0] eg, input logic ec, es, input logic [15:0] ea,
                                input logic ea0, ea1, es0, es1, input logic [3:0] eo);
        vec_t v;
        v.m0_cyc = m0c;  v.m0_stb = m0s;  v.m0_adr = m0a;
        v.m1_cyc = m1c;  v.m1_stb = m1s;  v.m1_adr = m1a;
        v.ack = ack;     v.stall = stall;
        v.e_gnt = eg;    v.e_cyc = ec;    v.e_stb = es;    v.e_adr = ea;
        v.e_m0_ack = ea0; v.e_m1_ack = ea1; v.e_m0_stall = es0; v.e_m1_stall = es1;
        v.e_out = eo;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk_i);
        m0_bus.cyc = v.m0_cyc;  m0_bus.stb = v.m0_stb;  m0_bus.adr = v.m0_adr;
        m1_bus.cyc = v.m1_cyc;  m1_bus.stb = v.m1_stb;  m1_bus.adr = v.m1_adr;
        s_bus.ack  = v.ack;     s_bus.stall = v.stall;
    endtask

    task automatic idleInputs();
        m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0; m0_bus.adr = '0; m0_bus.dat_w = 16'h1111;
        m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 0; m1_bus.adr = '0; m1_bus.dat_w = 16'h2222;
        s_bus.ack = 0; s_bus.err = 0; s_bus.stall = 0; s_bus.dat_r = 16'hBEEF;
    endtask

    initial begin
        int pulses, first_k, m1_pulses;
        idleInputs();
        #1;
        checkOutput("rst_gnt",      32'(gnt_o),         0);
        checkOutput("rst_s_cyc",    32'(s_bus.cyc),     0);
        checkOutput("rst_s_stb",    32'(s_bus.stb),     0);
        checkOutput("rst_s_we",     32'(s_bus.we),      0);
        checkOutput("rst_s_adr",    32'(s_bus.adr),     0);
        checkOutput("rst_m0_ack",   32'(m0_bus.ack),    0);
        checkOutput("rst_m1_err",   32'(m1_bus.err),    0);
        checkOutput("rst_m0_stall", 32'(m0_bus.stall),  1);
        checkOutput("rst_m1_stall", 32'(m1_bus.stall),  1);
        checkOutput("rst_out",      32'(outstanding_o), 0);
        @(negedge clk_i);
        reset_ni = 1'b1;

        //                m0c m0s adr      m1c m1s adr      ack stl  gnt ec es eadr     a0 a1 s0 s1 out
        vecs[0]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2'b00, 0, 0, 16'h0000, 0, 0, 1, 1, 0);
        vecs[1]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2'b00, 0, 0, 16'h0000, 0, 0, 1, 1, 0);
        vecs[2]  = mk(1, 1, 16'h1234, 0, 0, 16'h0000, 0, 0, 2'b01, 1, 1, 16'h1234, 0, 0, 0, 1, 0);
        vecs[3]  = mk(1, 0, 16'h1234, 0, 0, 16'h0000, 1, 0, 2'b01, 1, 0, 16'h1234, 1, 0, 0, 1, 1);
        vecs[4]  = mk(1, 1, 16'h0002, 0, 0, 16'h0000, 0, 0, 2'b01, 1, 1, 16'h0002, 0, 0, 0, 1, 0);
        vecs[5]  = mk(1, 1, 16'h0003, 0, 0, 16'h0000, 0, 0, 2'b01, 1, 1, 16'h0003, 0, 0, 0, 1, 1);
        vecs[6]  = mk(1, 1, 16'h0004, 0, 0, 16'h0000, 0, 0, 2'b01, 1, 1, 16'h0004, 0, 0, 0, 1, 2);
        vecs[7]  = mk(1, 1, 16'h0005, 0, 0, 16'h0000, 1, 0, 2'b01, 1, 1, 16'h0005, 1, 0, 0, 1, 3);
        vecs[8]  = mk(1, 0, 16'h0005, 0, 0, 16'h0000, 1, 0, 2'b01, 1, 0, 16'h0005, 1, 0, 0, 1, 3);
        vecs[9]  = mk(1, 0, 16'h0005, 0, 0, 16'h0000, 1, 0, 2'b01, 1, 0, 16'h0005, 1, 0, 0, 1, 2);
        vecs[10] = mk(1, 0, 16'h0005, 0, 0, 16'h0000, 1, 0, 2'b01, 1, 0, 16'h0005, 1, 0, 0, 1, 1);
        vecs[11] = mk(1, 0, 16'h0005, 0, 0, 16'h0000, 0, 0, 2'b01, 1, 0, 16'h0005, 0, 0, 0, 1, 0);
        vecs[12] = mk(1, 1, 16'h0006, 1, 0, 16'h0000, 0, 1, 2'b01, 1, 1, 16'h0006, 0, 0, 1, 1, 0);
        vecs[13] = mk(1, 1, 16'h0006, 1, 0, 16'h0000, 0, 1, 2'b01, 1, 1, 16'h0006, 0, 0, 1, 1, 0);
        vecs[14] = mk(1, 0, 16'h0006, 1, 0, 16'h0000, 1, 0, 2'b01, 1, 0, 16'h0006, 1, 0, 0, 1, 0);
        vecs[15] = mk(0, 0, 16'h0000, 1, 1, 16'hAAAA, 0, 0, 2'b01, 0, 0, 16'h0000, 0, 0, 0, 1, 0);
        vecs[16] = mk(0, 0, 16'h0000, 1, 1, 16'hAAAA, 0, 0, 2'b10, 1, 1, 16'hAAAA, 0, 0, 1, 0, 0);
        vecs[17] = mk(0, 0, 16'h0000, 0, 0, 16'hAAAA, 0, 0, 2'b10, 0, 0, 16'hAAAA, 0, 0, 1, 0, 1);
        vecs[18] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 2'b00, 0, 0, 16'h0000, 0, 0, 1, 1, 0);
        vecs[19] = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 2'b00, 0, 0, 16'h0000, 0, 0, 1, 1, 0);
        vecs[20] = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 2'b01, 1, 0, 16'h0000, 0, 0, 0, 1, 0);
        vecs[21] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 2'b01, 0, 0, 16'h0000, 0, 0, 0, 1, 0);
        vecs[22] = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 2'b10, 1, 0, 16'h0000, 0, 0, 1, 0, 0);
        vecs[23] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2'b10, 0, 0, 16'h0000, 0, 0, 1, 0, 0);
        vecs[24] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2'b01, 1, 0, 16'h0000, 0, 0, 0, 1, 0);

        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d_gnt", i),      32'(gnt_o),         32'(vecs[i].e_gnt));
            checkOutput($sformatf("row%0d_s_cyc", i),    32'(s_bus.cyc),     32'(vecs[i].e_cyc));
            checkOutput($sformatf("row%0d_s_stb", i),    32'(s_bus.stb),     32'(vecs[i].e_stb));
            checkOutput($sformatf("row%0d_s_adr", i),    32'(s_bus.adr),     32'(vecs[i].e_adr));
            checkOutput($sformatf("row%0d_m0_ack", i),   32'(m0_bus.ack),    32'(vecs[i].e_m0_ack));
            checkOutput($sformatf("row%0d_m1_ack", i),   32'(m1_bus.ack),    32'(vecs[i].e_m1_ack));
            checkOutput($sformatf("row%0d_m0_stall", i), 32'(m0_bus.stall),  32'(vecs[i].e_m0_stall));
            checkOutput($sformatf("row%0d_m1_stall", i), 32'(m1_bus.stall),  32'(vecs[i].e_m1_stall));
            checkOutput($sformatf("row%0d_out", i),      32'(outstanding_o), 32'(vecs[i].e_out));
        end
        checkOutput("bcast_m0_dat", 32'(m0_bus.dat_r), 32'h0000BEEF);
        checkOutput("bcast_m1_dat", 32'(m1_bus.dat_r), 32'h0000BEEF);
        checkOutput("wdata_mux",    32'(s_bus.dat_w),  32'h00001111);

        // The counter saturates at 15 after 17 accepted strobes, and then one ack takes it to 14.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk_i);
            m0_bus.stb = 1'b1;
        end
        @(negedge clk_i);
        m0_bus.stb = 1'b0;
        #1 checkOutput("sat_out", 32'(outstanding_o), 15);
        @(negedge clk_i);
        s_bus.ack = 1'b1;
        @(negedge clk_i);
        s_bus.ack = 1'b0;
        #1 checkOutput("sat_dec_out", 32'(outstanding_o), 14);

        // An asynchronous reset with two strobes in flight aborts the burst without a clock edge.
        @(negedge clk_i);
        reset_ni = 1'b0;
        idleInputs();
        @(negedge clk_i);
        reset_ni = 1'b1;
        m0_bus.cyc = 1'b1;
        @(negedge clk_i);
        m0_bus.stb = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        m0_bus.stb = 1'b0;
        #1 checkOutput("burst_out", 32'(outstanding_o), 2);
        #1 reset_ni = 1'b0;
        #1;
        checkOutput("arst_s_cyc",    32'(s_bus.cyc),     0);
        checkOutput("arst_gnt",      32'(gnt_o),         0);
        checkOutput("arst_out",      32'(outstanding_o), 0);
        checkOutput("arst_m0_stall", 32'(m0_bus.stall),  1);

        // One strobe is accepted, and the slave never answers.
        idleInputs();
        @(negedge clk_i);
        reset_ni   = 1'b1;
        m0_bus.cyc = 1'b1;
        @(negedge clk_i);
        m0_bus.stb = 1'b1;
        @(negedge clk_i);
        m0_bus.stb = 1'b0;
        pulses = 0;
        first_k = 0;
        m1_pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (m0_bus.err) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
            if (m1_bus.err) m1_pulses++;
            @(negedge clk_i);
        end
        checkOutput("wd_m1_err", 32'(m1_pulses), 0);
`ifdef WB_ARB2_TIMEOUT_EN
        checkOutput("wd_pulses", 32'(pulses),        1);
        checkOutput("wd_cycle",  32'(first_k),       8);
        checkOutput("wd_out",    32'(outstanding_o), 0);
`else
        checkOutput("wd_pulses", 32'(pulses),        0);
        checkOutput("wd_out",    32'(outstanding_o), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
